// File: rtl/hm01b0_mcu_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hm01b0_mcu_reader_pkg
//  Description : Constants and types shared by the hm01b0 MCU band store.
//                The ingester (write side) and the reader (read side) both
//                use them. Contents: default geometry, MCU size, reader FSM
//                encoding and the pixel tag bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
package hm01b0_mcu_reader_pkg;

  // Default geometry: a 320-pixel-wide image gives 40 MCUs per 8-line band.
  // The band is spread over 5 EBRs of 512 bytes in each buffer half.
  localparam int WIDTH_PIX_DEFAULT = 320;
  localparam int NUM_EBR_DEFAULT   = 5;
  localparam int EBR_SIZE_DEFAULT  = 512;

  localparam int MCU_PIX       = 64;
  localparam int MCUS_PER_BAND = WIDTH_PIX_DEFAULT / 8;

  // Pixel byte plus three tag bits travel together through the output fifo.
  localparam int TAG_W       = 3;
  localparam int FIFO_DATA_W = 8 + TAG_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } reader_state_t;

  typedef struct packed {
    logic first;      // pixel 0 of an MCU
    logic last;       // pixel 63 of an MCU
    logic band_last;  // pixel 63 of the final MCU of the band
  } pix_tag_t;

  // Bit width needed to index 'n' items, never less than one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/hm01b0_mcu_reader_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mcu_pixel_fifo
//  Description : Two-entry register fifo for tagged pixels on the reader
//                output. It accepts a push while full if the head is popped
//                in the same cycle.
//  Ports       : clock, reset      - system clock, async active-high reset
//                push, push_data   - write strobe and tagged pixel
//                pop               - consume the head entry
//                head_data         - current head entry
//                head_valid        - fifo holds at least one entry
//                count             - occupancy, 0..2
//  Revision    : 1.0 - initial release
// ============================================================================
module mcu_pixel_fifo
  import hm01b0_mcu_reader_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_valid,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign do_pop  = pop && (count != 2'd0);
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + 2'(do_push) - 2'(do_pop);
    end
  end

  assign head_data  = mem[rd_ptr];
  assign head_valid = (count != 2'd0);

endmodule
`default_nettype wire

// File: rtl/hm01b0_mcu_reader.sv
`default_nettype none
// ============================================================================
//  Module      : hm01b0_mcu_reader
//  Description : Read side of the double-buffered MCU band store. A toggle
//                of frontbuffer_select marks a completed band. The block then
//                reads that half back MCU by MCU, 64 raster-order pixels per
//                MCU, and streams the pixels over valid/ready.
//  Ports       : clock, reset          - system clock, async active-high reset
//                frontbuffer_select    - ingester write half; toggle = band done
//                rd_en                 - EBR read strobe
//                rd_buffer_select      - half being read
//                rd_block_select       - EBR index (MCU % NUM_EBR)
//                rd_addr               - {MCU / NUM_EBR, py, px}
//                rd_data               - EBR data, one cycle after rd_en
//                out_pixval/out_valid  - pixel stream, handshake with out_ready
//                out_mcu_first/_last   - MCU boundary tags
//                out_band_last         - last pixel of the band
//                overrun               - sticky: flip arrived mid-band
//  Revision    : 1.0 - initial release
// ============================================================================
module hm01b0_mcu_reader
  import hm01b0_mcu_reader_pkg::*;
#(
  parameter  int WIDTH_PIX = WIDTH_PIX_DEFAULT,
  parameter  int NUM_EBR   = NUM_EBR_DEFAULT,
  parameter  int EBR_SIZE  = EBR_SIZE_DEFAULT,
  localparam int BLK_W     = idx_width(NUM_EBR),
  localparam int ADDR_W    = idx_width(EBR_SIZE)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              frontbuffer_select,
  output logic              rd_en,
  output logic              rd_buffer_select,
  output logic [BLK_W-1:0]  rd_block_select,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        out_pixval,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_mcu_first,
  output logic              out_mcu_last,
  output logic              out_band_last,
  output logic              overrun
);

  localparam int MCUS      = WIDTH_PIX / 8;
  localparam int MCU_W     = idx_width(MCUS + 1);
  localparam int DIV_W     = ADDR_W - 6;
  localparam int MCU_SLOTS = (MCUS + NUM_EBR - 1) / NUM_EBR;

  // Each EBR must hold its share of MCUs. The address is a plain
  // {slot, pixel} concatenation, so at least one slot bit must exist
  // above the 6 pixel bits.
  generate
    if ((MCU_SLOTS * MCU_PIX > EBR_SIZE) || (DIV_W < 1)) begin : g_size_check
      $error("hm01b0_mcu_reader: band does not fit EBR geometry");
    end
  endgenerate

  reader_state_t    state;
  logic             fsel_prev;
  logic             pending;
  logic [5:0]       pix;
  logic [BLK_W-1:0] blk;
  logic [DIV_W-1:0] mcu_div;
  logic [MCU_W-1:0] mcu;
  logic             inflight;
  pix_tag_t         inflight_tag;

  logic             flip;
  logic             pop;
  logic [1:0]       fifo_count;
  logic [2:0]       occupancy;
  logic             issue;
  logic             pix_last;
  logic             mcu_last;
  logic             blk_last;
  logic             drained;
  pix_tag_t         issue_tag;
  pix_tag_t         head_tag;
  logic [FIFO_DATA_W-1:0] head_data;

  assign flip     = frontbuffer_select ^ fsel_prev;
  assign pop      = out_valid && out_ready;
  assign pix_last = (pix == 6'd63);
  assign mcu_last = (mcu == MCU_W'(MCUS - 1));
  assign blk_last = (blk == BLK_W'(NUM_EBR - 1));
  assign drained  = (fifo_count == 2'd0) && !inflight;

  // The fifo slots still committed after this cycle: current entries,
  // minus the one leaving now, plus the read whose data lands this cycle.
  // A new read is issued only if its data is certain to find room. Counting
  // this cycle's pop keeps one pixel per cycle with a 2-entry fifo. rd_en is
  // therefore combinational.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign issue     = (state == ST_READ) && (occupancy < 3'd2);

  assign issue_tag = '{first:     (pix == 6'd0),
                       last:      pix_last,
                       band_last: pix_last && mcu_last};

  assign rd_en           = issue;
  assign rd_block_select = blk;
  assign rd_addr         = {mcu_div, pix};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= ST_IDLE;
      fsel_prev        <= frontbuffer_select;
      pending          <= 1'b0;
      overrun          <= 1'b0;
      rd_buffer_select <= 1'b0;
      pix              <= '0;
      blk              <= '0;
      mcu_div          <= '0;
      mcu              <= '0;
      inflight         <= 1'b0;
      inflight_tag     <= '0;
    end else begin
      fsel_prev <= frontbuffer_select;
      inflight  <= issue;
      if (issue) begin
        inflight_tag <= issue_tag;
      end

      case (state)
        ST_IDLE: begin
          if (flip) begin
            rd_buffer_select <= ~frontbuffer_select;
            pix              <= '0;
            blk              <= '0;
            mcu_div          <= '0;
            mcu              <= '0;
            state            <= ST_READ;
          end
        end

        ST_READ: begin
          if (flip) begin
            overrun <= 1'b1;
            pending <= 1'b1;
          end
          if (issue) begin
            if (pix_last) begin
              pix <= '0;
              mcu <= mcu + MCU_W'(1);
              if (blk_last) begin
                blk     <= '0;
                mcu_div <= mcu_div + DIV_W'(1);
              end else begin
                blk <= blk + BLK_W'(1);
              end
              if (mcu_last) begin
                state <= ST_DRAIN;
              end
            end else begin
              pix <= pix + 6'd1;
            end
          end
        end

        ST_DRAIN: begin
          if (drained && (pending || flip)) begin
            // Restart straight into the completed half the ingester is
            // not writing. A flip with nothing pending is the same as a
            // flip seen in IDLE.
            rd_buffer_select <= ~frontbuffer_select;
            pix              <= '0;
            blk              <= '0;
            mcu_div          <= '0;
            mcu              <= '0;
            pending          <= 1'b0;
            state            <= ST_READ;
            if (pending && flip) begin
              overrun <= 1'b1;
            end
          end else if (drained) begin
            state <= ST_IDLE;
          end else if (flip) begin
            overrun <= 1'b1;
            pending <= 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  // rd_data is valid the cycle after rd_en, so it pairs with inflight.
  mcu_pixel_fifo #(
    .DATA_W (FIFO_DATA_W)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (inflight),
    .push_data  ({rd_data, inflight_tag}),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (out_valid),
    .count      (fifo_count)
  );

  assign head_tag      = pix_tag_t'(head_data[TAG_W-1:0]);
  assign out_pixval    = head_data[FIFO_DATA_W-1:TAG_W];
  assign out_mcu_first = head_tag.first;
  assign out_mcu_last  = head_tag.last;
  assign out_band_last = head_tag.band_last;

endmodule
`default_nettype wire
